// File: rtl/bus_master_if_if.sv
// ---------------------------------------------------------------------------
// bus_master_if_if
//   Shared word-bus signal bundle between an initiator (bus_master_if) and
//   the arbiter / slave-side read mux. Trailing '_' marks active-low signals.
//
//   master modport : drives bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
//                    samples bus_grnt_, bus_rd_data, bus_rdy_
//   slave modport  : the mirror image (arbiter + slave mux side)
// ---------------------------------------------------------------------------
interface bus_master_if_if;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if
//   Initiator-side bus interface. Turns a single-cycle core access (as_ low
//   in IDLE) into the full bus sequence: request -> arbiter grant -> one-cycle
//   address strobe -> wait for slave ready. Read data is returned through an
//   internal buffer (rd_buf) that is held while the core is stalled.
//
//   Ports:
//     clk, reset     single clock, asynchronous active-high reset
//     as_, rw, addr, wr_data   core access request (as_ active-low)
//     stall, flush   core pipeline control
//     rd_data        read data to the core (rd_buf)
//     busy           core must stall while high (combinational)
//     err            one-cycle bus timeout pulse
//     bus            bus_master_if_if.master; all bus outputs are registered
//
//   Optional feature: define BUS_TIMEOUT_EN to build the ACCESS-state
//   timeout counter (TIMEOUT_CYCLES, 1..255). Without it err is tied 0 and
//   ACCESS waits for the slave indefinitely.
// ---------------------------------------------------------------------------
module bus_master_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [29:0]           addr,
  input  logic [31:0]           wr_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic [31:0]           rd_data,
  output logic                  busy,
  output logic                  err,
  bus_master_if_if.master       bus
);

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;

  // Elaboration-time sanity check on the timeout length (8-bit counter).
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_master_if: TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACCESS = 2'd2,
    S_STALL  = 2'd3
  } state_t;

  // Latched core request; drives the registered bus outputs directly.
  typedef struct packed {
    logic [29:0] addr;
    logic        rw;
    logic [31:0] wr_data;
  } bus_cmd_t;

  state_t   state, state_nxt;
  bus_cmd_t cmd_q;
  logic     req_q;
  logic     as_q;
  logic [31:0] rd_buf;

  // Per-cycle control strobes decoded by the FSM.
  logic accept;     // IDLE takes a new core request
  logic grant_go;   // REQ sees grant: strobe address next cycle
  logic done;       // ACCESS completes (ready or timeout)
  logic timeout;    // completion caused by timeout
  logic to_hit;     // timeout counter reached its last cycle

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next state, busy and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    grant_go  = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        // flush masks the strobe so a squashed instruction never reaches the bus
        if (as_ == ENABLE_ && !flush) begin
          busy      = 1'b1;
          accept    = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        busy = 1'b1;
        if (bus.bus_grnt_ == ENABLE_) begin
          grant_go  = 1'b1;
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy = 1'b1;
        // A real ready wins over a coincident timeout.
        if (bus.bus_rdy_ == ENABLE_) begin
          done = 1'b1;
        end else if (to_hit) begin
          done    = 1'b1;
          timeout = 1'b1;
        end
        if (done) state_nxt = stall ? S_STALL : S_IDLE;
      end
      S_STALL: begin
        // Result is complete; core may still be frozen. New strobes wait.
        if (!stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered bus outputs and read buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q         <= DISABLE_;
      as_q          <= DISABLE_;
      cmd_q.addr    <= '0;
      cmd_q.rw      <= READ;
      cmd_q.wr_data <= '0;
      rd_buf        <= '0;
    end else begin
      if (accept) begin
        cmd_q.addr    <= addr;
        cmd_q.rw      <= rw;
        cmd_q.wr_data <= wr_data;
        req_q         <= ENABLE_;
      end
      // Strobe is raised for the first ACCESS cycle only.
      if (grant_go)               as_q <= ENABLE_;
      else if (state == S_ACCESS) as_q <= DISABLE_;
      if (done) begin
        req_q <= DISABLE_;
        if (timeout)                rd_buf <= '0;
        else if (cmd_q.rw == READ)  rd_buf <= bus.bus_rd_data;
      end
    end
  end

  assign bus.bus_req_     = req_q;
  assign bus.bus_as_      = as_q;
  assign bus.bus_addr     = cmd_q.addr;
  assign bus.bus_rw       = cmd_q.rw;
  assign bus.bus_wr_data  = cmd_q.wr_data;
  assign rd_data          = rd_buf;

  // -------------------------------------------------------------------------
  // Optional ACCESS timeout
  // -------------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt;
  logic       err_q;

  // Counter is 0 in the first ACCESS cycle, so the TIMEOUT_CYCLES-th
  // ready-less ACCESS cycle is the one that aborts.
  assign to_hit = (state == S_ACCESS) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout;
      if (grant_go)
        to_cnt <= '0;
      else if (state == S_ACCESS && bus.bus_rdy_ == DISABLE_)
        to_cnt <= to_cnt + 8'd1;
    end
  end

  assign err = err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: doc/bus_master_if.md
# bus_master_if

Initiator-side bus interface between a CPU memory-access port and the shared word bus. It converts a single-cycle core access request into the full bus protocol: request, wait for arbiter grant, address strobe, wait for slave ready. It returns read data and a busy/stall indication to the core. Its bus inputs `bus_rd_data`/`bus_rdy_` are driven by the slave-side read mux (`m_rd_data`/`m_rdy_`). Bus signals with a trailing `_` are active-low (`ENABLE_`=0, `DISABLE_`=1); `READ`=1, `WRITE`=0.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: ACCESS-state cycles without `bus_rdy_` before abort (only with `BUS_TIMEOUT_EN`); range 1..255, 8-bit counter.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- as_  in  1  core access strobe, active-low, sampled in IDLE only.
- rw  in  1  core direction, READ=1 / WRITE=0.
- addr  in  30  core word address.
- wr_data  in  32  core write data.
- stall  in  1  core pipeline stall; holds completed result.
- flush  in  1  core flush; suppresses acceptance of a new request.
- rd_data  out  32  read data to core (from internal rd_buf).
- busy  out  1  core must stall while 1.
- err  out  1  one-cycle pulse on bus timeout (tied 0 without macro).
- bus_req_  out  1  arbiter request, registered.
- bus_grnt_  in  1  arbiter grant.
- bus_addr  out  30  bus address, registered.
- bus_as_  out  1  bus address strobe, registered.
- bus_rw  out  1  bus direction, registered.
- bus_wr_data  out  32  bus write data, registered.
- bus_rd_data  in  32  read data from slave mux.
- bus_rdy_  in  1  ready from slave mux.

## Operation
- Reset values:
  - bus_req_=1, bus_as_=1.
  - bus_addr=0, bus_rw=READ, bus_wr_data=0.
  - rd_buf=0, so rd_data=0.
  - err=0, timeout counter=0, state IDLE.
- States IDLE, REQ, ACCESS, STALL.
- IDLE:
  - If as_=0 and flush=0: latch addr/rw/wr_data into the bus_* registers, set bus_req_=0, go to REQ. busy=1 combinationally in this same cycle.
  - Otherwise busy=0 and the state holds.
  - as_=0 with flush=1 is ignored.
- REQ:
  - busy=1.
  - When bus_grnt_=0: set bus_as_=0 for exactly one cycle, clear the counter, go to ACCESS.
  - Otherwise the state holds; the request stays asserted.
- ACCESS:
  - busy=1.
  - bus_addr, bus_rw and bus_wr_data stay stable from REQ until the state leaves ACCESS.
  - On bus_rdy_=0: if bus_rw=READ, capture bus_rd_data into rd_buf; a write leaves rd_buf unchanged. Set bus_req_=1. Go to STALL if stall=1, else to IDLE.
- STALL:
  - busy=0; rd_data=rd_buf is held.
  - Go to IDLE when stall=0.
  - A new as_ is not accepted until the block is back in IDLE.
- busy is combinational from the state, as_ and flush. All bus outputs are registered.
- flush or stall outside IDLE never aborts a bus transaction in progress.

## Timing
- Zero-wait path (grant and rdy_ both already low):
  - Cycle 0: IDLE accepts; busy=1.
  - Cycle 1: REQ, bus_req_=0.
  - Cycle 2: ACCESS, bus_as_=0.
  - Cycle 3: IDLE, busy=0, rd_data valid.
  - Total: 3 busy cycles.
- Each cycle of grant delay or slave wait state adds exactly one busy cycle.
- bus_as_ is low for exactly one cycle per transaction. bus_req_ is low from the REQ cycle through the last ACCESS cycle.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously, and the bus request is dropped with no completion.

## Configuration
- BUS_TIMEOUT_EN defined:
  - An 8-bit counter increments each ACCESS cycle while bus_rdy_=1.
  - The cycle in which the counter equals TIMEOUT_CYCLES-1 is treated as completion with rd_buf=0, bus_req_=1 and err=1 for one cycle, then the next state is chosen as on a normal completion.
- Not defined: no counter is built, err is tied 0, and ACCESS waits indefinitely.

## Test plan
- Read, grant and rdy_ held low, addr=30'h100, bus_rd_data=32'hDEADBEEF -> bus_as_ low in cycle 2 only; busy high in cycles 0–2; rd_data=32'hDEADBEEF in cycle 3.
- Write with grant delayed 4 cycles, rdy_ delayed 2 cycles -> bus_addr, bus_rw and bus_wr_data stable throughout; busy high for 9 cycles; rd_buf unchanged.
- Completion with stall=1 for 3 cycles -> STALL state, busy=0, rd_data held; IDLE when stall drops; as_ held low during STALL is not accepted.
- as_=0 together with flush=1 in IDLE -> bus_req_ stays 1, busy=0.
- Reset pulsed in ACCESS -> bus_req_=1, bus_as_=1, rd_data=0 immediately, state IDLE.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and rdy_ never asserted -> err pulses after 4 ACCESS cycles, rd_data=0, bus_req_=1, busy=0 in the next cycle.
